cpu5_dmem_resp: RTL and testbench
=================================

// Module: cpu5_dmem_resp
// PURPOSE
//   Responder end of the cpu5 core data-memory port: accepts the core's memwrite/aluout/
//   writedata and returns readdata. Stores are posted into a small store buffer and drained
//   into a word-addressed backing array, one per cycle. Loads return with zero latency,
//   forwarded from the store buffer when a store to that word is still pending.
//   A loader port shares the array write port and has priority over drain. Sits beside the core in the top level.
// PARAMETERS
//   MEM_WORDS  256  backing array depth in 32-bit words (power of 2); AW = $clog2(MEM_WORDS)
//   SB_DEPTH   4    store-buffer entries (power of 2, >=2)
// PORTS
//   clk        in   1      single clock, all state on posedge
//   reset      in   1      asynchronous, active-low reset
//   memwrite   in   1      core store request this cycle
//   aluout     in   32     core byte address ([`CPU5_XLEN:0])
//   writedata  in   32     core store data
//   readdata   out  32     load data for aluout, combinational
//   stall      out  1      store not accepted; core must hold the instruction
//   sb_empty   out  1      no pending stores (fence/idle indicator)
//   ldr_we     in   1      loader array write, highest priority
//   ldr_addr   in   AW     loader word index
//   ldr_wdata  in   32     loader write data
// BEHAVIOUR
//   - Word index idx = aluout[AW+1:2]. aluout[1:0] and bits above AW+1 are ignored, so the address wraps modulo MEM_WORDS.
//   - Reset (async, reset==0): head/tail/count=0, all entry valids cleared, stall=0, sb_empty=1.
//     The array is not reset. Pending stores are discarded, including when reset lands mid-drain.
//   - stall = memwrite & (count==SB_DEPTH). Combinational. Stall uses full, not full-after-pop.
//   - Enqueue: at posedge, if memwrite & ~stall, write {idx, writedata} at tail; tail++.
//   - Drain: at posedge, if count!=0 & ~ldr_we, array[head.idx] <= head.data; head++.
//   - Loader: at posedge, if ldr_we, array[ldr_addr] <= ldr_wdata. Drain is blocked that cycle.
//   - Same-cycle enqueue+drain: count unchanged. Pointers wrap modulo SB_DEPTH.
//   - readdata: data of the youngest valid entry whose idx==idx, else array[idx]. Asynchronous read.
//     An entry enqueued in cycle N is visible to reads from cycle N+1 on. Same-cycle store data is not forwarded.
//   - Loader vs pending store to the same word: the pending store drains later and wins.
//   - sb_empty = (count==0). Max store-to-array latency = SB_DEPTH + cycles with ldr_we high.
// STRUCTURE
//   - Shared defines: `CPU5_XLEN` (already defined), plus new `CPU5_DMEM_WORDS` and
//     `CPU5_SB_DEPTH` defaults.
//   - Sub-module cpu5_store_buf: circular FIFO (head/tail/count) with a per-entry idx compare.
//     Its youngest-match priority mux produces fwd_hit/fwd_data.
//   - Top level holds the array, write-port arbitration (ldr > drain) and the readdata mux.
// TESTING
//   1. Reset mid-traffic: enqueue 3 stores, pull reset low -> sb_empty=1 and stall=0 immediately;
//      after release, the array is unchanged at those words.
//   2. Store 0xDEADBEEF @0x10, load 0x10 next cycle -> readdata=0xDEADBEEF (forward).
//      After drain, sb_empty=1 and load 0x10 still reads 0xDEADBEEF (array).
//   3. Two stores to 0x20 (0x1, then 0x2), then load 0x20 -> readdata=0x2 (youngest match), both before and after drain.
//   4. Hold ldr_we=1 for 6 cycles while the core issues 5 stores -> stall=1 on the 5th store.
//      Drop ldr_we -> stall clears next cycle, all 5 reach the array in order.
//   5. Loader writes 0xAAAA to word 8 while a store of 0x5555 to aluout 0x20 (word 8) is pending -> final array[8]=0x5555.
//   6. aluout=0x0000_0403, MEM_WORDS=256 -> idx=0 (wrap, low bits ignored).
//      Store/load round-trips to 0x0.

Source files
------------

// File: rtl/cpu5_dmem_resp_pkg.sv
// rtl/cpu5_dmem_resp_pkg.sv - shared defines, defaults and types for the cpu5 data-memory responder
// Contents: CPU5_XLEN / CPU5_DMEM_WORDS / CPU5_SB_DEPTH defaults, default parameters, word type.
`ifndef CPU5_XLEN
`define CPU5_XLEN 31
`endif
`ifndef CPU5_DMEM_WORDS
`define CPU5_DMEM_WORDS 256
`endif
`ifndef CPU5_SB_DEPTH
`define CPU5_SB_DEPTH 4
`endif

package cpu5_dmem_resp_pkg;
  localparam int DEF_MEM_WORDS = `CPU5_DMEM_WORDS;
  localparam int DEF_SB_DEPTH  = `CPU5_SB_DEPTH;

  typedef logic [31:0] word_t;
endpackage

// File: rtl/cpu5_dmem_resp_if.sv
// rtl/cpu5_dmem_resp_if.sv - core/loader side bus of the cpu5 data-memory responder
// Signals: memwrite/aluout/writedata (core store/load request), readdata/stall/sb_empty (response),
//          ldr_we/ldr_addr/ldr_wdata (loader array write). master = core+loader, slave = responder.
interface cpu5_dmem_resp_if #(
  parameter int AW = 8
);
  import cpu5_dmem_resp_pkg::*;

  logic              memwrite;
  logic [`CPU5_XLEN:0] aluout;
  word_t             writedata;
  word_t             readdata;
  logic              stall;
  logic              sb_empty;
  logic              ldr_we;
  logic [AW-1:0]     ldr_addr;
  word_t             ldr_wdata;

  modport master (
    output memwrite, aluout, writedata, ldr_we, ldr_addr, ldr_wdata,
    input  readdata, stall, sb_empty
  );

  modport slave (
    input  memwrite, aluout, writedata, ldr_we, ldr_addr, ldr_wdata,
    output readdata, stall, sb_empty
  );
endinterface

// File: rtl/cpu5_store_buf.sv
// rtl/cpu5_store_buf.sv - circular store buffer with youngest-match load forwarding
// Ports: clk, reset (async active-low); i_push/i_push_idx/i_push_data enqueue at tail;
//        i_pop drops head, o_head_idx/o_head_data expose it; o_full/o_empty status;
//        i_rd_idx lookup key, o_fwd_hit/o_fwd_data youngest matching pending store.
module cpu5_store_buf
  import cpu5_dmem_resp_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_idx,
  input  word_t         i_push_data,
  input  logic          i_pop,
  output logic [AW-1:0] o_head_idx,
  output word_t         o_head_data,
  output logic          o_full,
  output logic          o_empty,
  input  logic [AW-1:0] i_rd_idx,
  output logic          o_fwd_hit,
  output word_t         o_fwd_data
);
  localparam int PW = $clog2(SB_DEPTH);

  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [PW:0]         r_count;
  logic [SB_DEPTH-1:0] r_valid;
  logic [AW-1:0]       r_idx  [SB_DEPTH];
  word_t               r_data [SB_DEPTH];

  assign o_full      = (r_count == (PW+1)'(SB_DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_idx  = r_idx[r_head];
  assign o_head_data = r_data[r_head];

  // Callers never push when full or pop when empty, so push and pop
  // never touch the same valid bit in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_idx[r_tail]  <= i_push_idx;
      r_data[r_tail] <= i_push_data;
    end
  end

  // Walk oldest -> youngest from head; a later match overrides, leaving the youngest.
  always_comb begin
    logic [PW-1:0] v_ptr;
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    v_ptr      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      v_ptr = r_head + PW'(k);
      if (r_valid[v_ptr] && (r_idx[v_ptr] == i_rd_idx)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = r_data[v_ptr];
      end
    end
  end
endmodule

// File: rtl/cpu5_dmem_resp.sv
// rtl/cpu5_dmem_resp.sv - cpu5 data-memory responder: posted stores, zero-latency forwarded loads
// Ports: clk, reset (async active-low), bus (cpu5_dmem_resp_if.slave): core request/response
//        and loader write port. Holds the backing array, ldr-over-drain arbitration, readdata mux.
module cpu5_dmem_resp
  import cpu5_dmem_resp_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int SB_DEPTH  = DEF_SB_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  cpu5_dmem_resp_if.slave  bus
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [AW-1:0] w_rd_idx;
  logic          w_unused_addr;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drain;
  logic [AW-1:0] w_head_idx;
  word_t         w_head_data;
  logic          w_fwd_hit;
  word_t         w_fwd_data;

  word_t r_mem [MEM_WORDS];

  // Byte offset and bits above the array range are dropped: addresses wrap.
  assign w_rd_idx      = bus.aluout[AW+1:2];
  assign w_unused_addr = ^{bus.aluout[`CPU5_XLEN:AW+2], bus.aluout[1:0]};

  // Stall looks at the current fill only; a drain in the same cycle does not free a slot early.
  assign bus.stall    = bus.memwrite & w_full;
  assign bus.sb_empty = w_empty;
  assign w_push       = bus.memwrite & ~w_full;
  assign w_drain      = ~w_empty & ~bus.ldr_we;

  cpu5_store_buf #(
    .SB_DEPTH (SB_DEPTH),
    .AW       (AW)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_idx  (w_rd_idx),
    .i_push_data (bus.writedata),
    .i_pop       (w_drain),
    .o_head_idx  (w_head_idx),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .i_rd_idx    (w_rd_idx),
    .o_fwd_hit   (w_fwd_hit),
    .o_fwd_data  (w_fwd_data)
  );

  // Single array write port: the loader wins, drain waits. The array keeps its contents over reset.
  always_ff @(posedge clk) begin
    if (bus.ldr_we) begin
      r_mem[bus.ldr_addr] <= bus.ldr_wdata;
    end else if (w_drain) begin
      r_mem[w_head_idx] <= w_head_data;
    end
  end

  assign bus.readdata = w_fwd_hit ? w_fwd_data : r_mem[w_rd_idx];
endmodule

// File: tb/tb_cpu5_dmem_resp.sv
// tb/tb_cpu5_dmem_resp.sv - self-checking bench for cpu5_dmem_resp
module tb_cpu5_dmem_resp;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu5_dmem_resp_if #(.AW(8)) bus();

  cpu5_dmem_resp #(.MEM_WORDS(256), .SB_DEPTH(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } st_t;

  st_t         q[$];
  logic [31:0] m_mem [256];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned widx(logic [31:0] a);
    return (a / 4) % 256;
  endfunction

  function automatic logic [31:0] m_read(int unsigned idx);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].idx == idx) return q[i].data;
    return m_mem[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit full;
    if (!rst_n) begin
      q.delete();
    end else begin
      full = (q.size() == 4);
      if (bus.ldr_we) begin
        m_mem[bus.ldr_addr] = bus.ldr_wdata;
      end else if (q.size() != 0) begin
        m_mem[q[0].idx] = q[0].data;
        void'(q.pop_front());
      end
      if (bus.memwrite && !full)
        q.push_back('{widx(bus.aluout), bus.writedata});
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("readdata", bus.readdata, m_read(widx(bus.aluout)));
      chk("stall", 32'(bus.stall), 32'(bus.memwrite && (q.size() == 4)));
      chk("sb_empty", 32'(bus.sb_empty), 32'(q.size() == 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.aluout    = a;
    bus.writedata = d;
    cyc();
    bus.memwrite  = 1'b0;
  endtask

  task automatic peek(string n, logic [31:0] a, logic [31:0] exp);
    bus.aluout = a;
    #1;
    chk(n, bus.readdata, exp);
  endtask

  task automatic drain(string n);
    int k;
    k = 0;
    while (!bus.sb_empty && k < 20) begin
      cyc();
      k++;
    end
    chk(n, 32'(bus.sb_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    bus.memwrite  = 1'b0;
    bus.aluout    = '0;
    bus.writedata = '0;
    bus.ldr_we    = 1'b0;
    bus.ldr_addr  = '0;
    bus.ldr_wdata = '0;

    // Reset state, with a store request present: stall must stay low.
    bus.memwrite = 1'b1;
    repeat (2) cyc();
    chk("rst_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    bus.memwrite = 1'b0;
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 256; i++) begin
      bus.ldr_we    = 1'b1;
      bus.ldr_addr  = 8'(i);
      bus.ldr_wdata = 32'h0BAD_0000 + i;
      cyc();
    end
    bus.ldr_we = 1'b0;
    cmp_en = 1'b1;
    peek("init_w5", 32'h14, 32'h0BAD_0005);

    // 1: reset with three stores pending (loader holds the drain off).
    bus.ldr_we    = 1'b1;
    bus.ldr_addr  = 8'd200;
    bus.ldr_wdata = 32'h77;
    store(32'h4, 32'h1111_1111);
    store(32'h8, 32'h2222_2222);
    store(32'hC, 32'h3333_3333);
    chk("t1_pending", 32'(bus.sb_empty), 32'd0);
    bus.ldr_we   = 1'b0;
    bus.memwrite = 1'b1;
    rst_n        = 1'b0;
    #1;
    chk("t1_rst_empty", 32'(bus.sb_empty), 32'd1);
    chk("t1_rst_stall", 32'(bus.stall), 32'd0);
    bus.memwrite = 1'b0;
    cyc();
    rst_n = 1'b1;
    peek("t1_w1", 32'h4, 32'h0BAD_0001);
    peek("t1_w2", 32'h8, 32'h0BAD_0002);
    peek("t1_w3", 32'hC, 32'h0BAD_0003);
    peek("t1_ldr", 32'h320, 32'h77);

    // 2: forward then array.
    store(32'h10, 32'hDEAD_BEEF);
    peek("t2_fwd", 32'h10, 32'hDEAD_BEEF);
    drain("t2_drain");
    peek("t2_arr", 32'h10, 32'hDEAD_BEEF);

    // 3: youngest match wins.
    store(32'h20, 32'h1);
    store(32'h20, 32'h2);
    peek("t3_young", 32'h20, 32'h2);
    drain("t3_drain");
    peek("t3_arr", 32'h20, 32'h2);

    // 4: loader blocks drain for 6 cycles, 5th store stalls until a slot frees.
    for (int i = 0; i < 8; i++) begin
      s = (i < 4) ? i : 4;
      bus.ldr_we    = (i < 6);
      bus.ldr_addr  = 8'(100 + i);
      bus.ldr_wdata = 32'hA000 + i;
      bus.memwrite  = 1'b1;
      bus.aluout    = 32'h200 + 4 * s;
      bus.writedata = 32'h4000 + s;
      #1;
      chk($sformatf("t4_stall_c%0d", i), 32'(bus.stall), (i >= 4 && i <= 6) ? 32'd1 : 32'd0);
      cyc();
    end
    bus.memwrite = 1'b0;
    bus.ldr_we   = 1'b0;
    drain("t4_drain");
    for (int i = 0; i < 5; i++)
      peek($sformatf("t4_w%0d", i), 32'h200 + 4 * i, 32'h4000 + i);
    peek("t4_ldr", 32'd400, 32'hA000);

    // 5: pending store beats a loader write to the same word.
    bus.memwrite  = 1'b1;
    bus.aluout    = 32'h20;
    bus.writedata = 32'h5555;
    bus.ldr_we    = 1'b1;
    bus.ldr_addr  = 8'd8;
    bus.ldr_wdata = 32'hAAAA;
    cyc();
    bus.memwrite = 1'b0;
    cyc();
    bus.ldr_we = 1'b0;
    drain("t5_drain");
    peek("t5_arr", 32'h20, 32'h5555);

    // 6: address wrap and byte-offset drop.
    store(32'h0000_0403, 32'h1234_5678);
    peek("t6_fwd", 32'h0, 32'h1234_5678);
    drain("t6_drain");
    peek("t6_arr0", 32'h0, 32'h1234_5678);
    peek("t6_arr403", 32'h403, 32'h1234_5678);

    cyc();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
